// File: rtl/panxi_pc_gen.sv
// panxi_pc_gen: next-PC generator for the PANXI IFU.
// Arbitrates prioritised redirect channels (index 0 highest), issues fetch
// addresses over a valid/ready request, and supports pipeline hold and a
// debug HALT state.
// Optional feature macro: PANXI_PC_ALIGN_CHK_EN rejects misaligned redirect
// targets and reports them on misalign_o / err_addr_o.
//
// Handshake: the request transfers on a clock edge where req_valid_o and
// req_ready_i are both 1. While ready is low the request stays up with the
// same address unless a redirect, hold or halt changes it.
module panxi_pc_gen #(
    parameter int          AW      = 32,
    parameter logic [AW-1:0] RST_VEC = '0,
    parameter int          STEP    = 4,
    parameter int          N_RDR   = 2,
    localparam int         IW      = (N_RDR > 1) ? $clog2(N_RDR) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_jtag_i,
    input  logic [N_RDR-1:0]  rdr_vld_i,
    input  logic [N_RDR*AW-1:0] rdr_addr_i,
    input  logic              hold_i,
    input  logic              halt_req_i,
    input  logic              req_ready_i,
    output logic              req_valid_o,
    output logic [AW-1:0]     req_addr_o,
    output logic              halted_o,
    output logic [IW-1:0]     rdr_idx_o,
    output logic              rdr_taken_o,
    output logic              misalign_o,
    output logic [AW-1:0]     err_addr_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            rdr_taken_q, rdr_taken_d;
    logic [IW-1:0]   rdr_idx_q, rdr_idx_d;

    logic            rst_all;
    logic            fire;
    logic            rdr_any;
    logic [IW-1:0]   win_idx;
    logic [AW-1:0]   win_addr;
    logic            win_bad;

    assign rst_all = rst | rst_jtag_i;

    // Only combinational output path: request valid from state and hold.
    assign req_valid_o = (state_q == ST_RUN) & ~hold_i;
    assign fire        = req_valid_o & req_ready_i;

    // Fixed-priority arbitration: lowest set index wins.
    always_comb begin
        rdr_any  = 1'b0;
        win_idx  = '0;
        win_addr = '0;
        for (int k = N_RDR - 1; k >= 0; k--) begin
            if (rdr_vld_i[k]) begin
                rdr_any  = 1'b1;
                win_idx  = IW'(k);
                win_addr = rdr_addr_i[k*AW +: AW];
            end
        end
    end

`ifdef PANXI_PC_ALIGN_CHK_EN
    // A misaligned winner is rejected outright; lower channels are not retried.
    assign win_bad = rdr_any & (win_addr[1:0] != 2'b00);
`else
    assign win_bad = 1'b0;
`endif

    // Next PC: redirect > hold > handshake > keep.
    always_comb begin
        pc_d = pc_q;
        if (rdr_any) begin
            if (!win_bad) begin
                pc_d = win_addr;
            end
        end else if (hold_i) begin
            pc_d = pc_q;
        end else if (fire) begin
            pc_d = pc_q + AW'(STEP);
        end
    end

    // Next state: BOOT lasts one cycle; halt_req_i level moves RUN <-> HALT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (halt_req_i)  state_d = ST_HALT;
            ST_HALT: if (!halt_req_i) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // Redirect report, registered one cycle after the redirect is applied.
    always_comb begin
        rdr_taken_d = rdr_any & ~win_bad;
        rdr_idx_d   = win_idx;
    end

    // State, PC and redirect report registers.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            state_q     <= ST_BOOT;
            pc_q        <= RST_VEC;
            rdr_taken_q <= 1'b0;
            rdr_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rdr_taken_q <= rdr_taken_d;
            rdr_idx_q   <= rdr_idx_d;
        end
    end

`ifdef PANXI_PC_ALIGN_CHK_EN
    logic            misalign_q, misalign_d;
    logic [AW-1:0]   err_addr_q, err_addr_d;

    // Misalign pulse and sticky record of the last rejected target.
    always_comb begin
        misalign_d = win_bad;
        err_addr_d = win_bad ? win_addr : err_addr_q;
    end

    // Misalign report registers.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            misalign_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            misalign_q <= misalign_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign misalign_o = misalign_q;
    assign err_addr_o = err_addr_q;
`else
    assign misalign_o = 1'b0;
    assign err_addr_o = '0;
`endif

    assign req_addr_o  = pc_q;
    assign halted_o    = (state_q == ST_HALT);
    assign rdr_taken_o = rdr_taken_q;
    assign rdr_idx_o   = rdr_idx_q;

endmodule

// File: tb/tb_panxi_pc_gen.sv
// Testbench for panxi_pc_gen: cycle-by-cycle vector table plus a short
// hand-written sequence (redirect against hold). Also builds with
// PANXI_PC_ALIGN_CHK_EN defined.
module tb_panxi_pc_gen;

  localparam int AW = 32;
  localparam logic [31:0] RV = 32'h8000_0000;

`ifdef PANXI_PC_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_jtag_i, hold_i, halt_req_i, req_ready_i;
  logic [1:0]  rdr_vld_i;
  logic [63:0] rdr_addr_i;
  logic        req_valid_o, halted_o, rdr_taken_o, misalign_o;
  logic [0:0]  rdr_idx_o;
  logic [31:0] req_addr_o, err_addr_o;

  panxi_pc_gen #(.AW(AW), .RST_VEC(RV), .STEP(4), .N_RDR(2)) dut (
    .clk(clk), .rst(rst), .rst_jtag_i(rst_jtag_i),
    .rdr_vld_i(rdr_vld_i), .rdr_addr_i(rdr_addr_i),
    .hold_i(hold_i), .halt_req_i(halt_req_i), .req_ready_i(req_ready_i),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .halted_o(halted_o),
    .rdr_idx_o(rdr_idx_o), .rdr_taken_o(rdr_taken_o),
    .misalign_o(misalign_o), .err_addr_o(err_addr_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, jtag;
    logic [1:0]  vld;
    logic [31:0] a0, a1;
    logic        hold, halt, ready;
    logic        e_v;
    logic [31:0] e_addr;
    logic        e_h, e_t, e_i, e_mis;
    logic [31:0] e_err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic j, input logic [1:0] v,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic hd, input logic ht, input logic rd,
                              input logic ev, input logic [31:0] ea, input logic eh,
                              input logic et, input logic ei, input logic em,
                              input logic [31:0] ee);
    vec_t x;
    x.rst = r; x.jtag = j; x.vld = v; x.a0 = a0; x.a1 = a1;
    x.hold = hd; x.halt = ht; x.ready = rd;
    x.e_v = ev; x.e_addr = ea; x.e_h = eh; x.e_t = et; x.e_i = ei;
    x.e_mis = em; x.e_err = ee;
    return x;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input vec_t x);
    rst = x.rst; rst_jtag_i = x.jtag; rdr_vld_i = x.vld;
    rdr_addr_i = {x.a1, x.a0};
    hold_i = x.hold; halt_req_i = x.halt; req_ready_i = x.ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pc_mis;
  logic        t_mis;
  logic [31:0] err_mis;

  initial begin
    // Outcome of a redirect to 0x102 depends on the alignment check.
    pc_mis  = ALIGN ? 32'h4 : 32'h102;
    t_mis   = ALIGN ? 1'b0 : 1'b1;
    err_mis = ALIGN ? 32'h102 : 32'h0;

    //       rst jt vld    a0            a1        hd ht rd | v  addr          h  t  i  mis   err
    vt.push_back(mk(1,0,2'b00,0,0,            0,0,0, 0,RV,          0,0,0,0,0));       // 0 reset state
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,1, 0,RV,          0,0,0,0,0));       // 1 BOOT
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,1, 1,RV,          0,0,0,0,0));       // 2
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,1, 1,RV+4,        0,0,0,0,0));       // 3
    vt.push_back(mk(0,0,2'b10,0,32'h10,       0,0,1, 1,RV+8,        0,0,0,0,0));       // 4 rdr ch1
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,0, 1,32'h10,      0,1,1,0,0));       // 5 ready low
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,0, 1,32'h10,      0,0,0,0,0));       // 6
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,0, 1,32'h10,      0,0,0,0,0));       // 7
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,1, 1,32'h10,      0,0,0,0,0));       // 8
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,1, 1,32'h14,      0,0,0,0,0));       // 9
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,1, 1,32'h18,      0,0,0,0,0));       // 10
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,1, 1,32'h1C,      0,0,0,0,0));       // 11
    vt.push_back(mk(0,0,2'b11,32'h100,32'h200,0,0,1, 1,32'h20,      0,0,0,0,0));       // 12 both chans + fire
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,1, 1,32'h100,     0,1,0,0,0));       // 13
    vt.push_back(mk(0,0,2'b00,0,0,            1,0,1, 0,32'h104,     0,0,0,0,0));       // 14 hold
    vt.push_back(mk(0,1,2'b00,0,0,            1,0,1, 0,32'h104,     0,0,0,0,0));       // 15 jtag reset mid-hold
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,1, 0,RV,          0,0,0,0,0));       // 16 BOOT
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,1, 1,RV,          0,0,0,0,0));       // 17
    vt.push_back(mk(0,0,2'b00,0,0,            0,1,1, 1,RV+4,        0,0,0,0,0));       // 18 halt + fire
    vt.push_back(mk(0,0,2'b01,32'h400,0,      0,1,1, 0,RV+8,        1,0,0,0,0));       // 19 rdr in HALT
    vt.push_back(mk(0,0,2'b00,0,0,            1,1,1, 0,32'h400,     1,1,0,0,0));       // 20 hold in HALT
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,1, 0,32'h400,     1,0,0,0,0));       // 21 drop halt
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,1, 1,32'h400,     0,0,0,0,0));       // 22 first fetch
    vt.push_back(mk(0,0,2'b01,32'hFFFF_FFFC,0,0,0,0, 1,32'h404,     0,0,0,0,0));       // 23
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,1, 1,32'hFFFF_FFFC,0,1,0,0,0));      // 24 wrap
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,1, 1,32'h0,       0,0,0,0,0));       // 25
    vt.push_back(mk(0,0,2'b10,0,32'h102,      0,0,0, 1,32'h4,       0,0,0,0,0));       // 26 misaligned tgt
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,0, 1,pc_mis,      0,t_mis,t_mis,ALIGN,err_mis)); // 27
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,0, 1,pc_mis,      0,0,0,0,err_mis)); // 28 err sticky
    vt.push_back(mk(1,0,2'b00,0,0,            0,0,1, 1,pc_mis,      0,0,0,0,err_mis)); // 29 reset
    vt.push_back(mk(0,0,2'b01,32'h40,0,       0,0,1, 0,RV,          0,0,0,0,0));       // 30 rdr in BOOT
    vt.push_back(mk(0,0,2'b00,0,0,            0,0,1, 1,32'h40,      0,1,0,0,0));       // 31

    // Establish a known state before the table starts.
    drive(vt[0]);
    tick();

    foreach (vt[r]) begin
      drive(vt[r]);
      #3;
      check("req_valid", r, {31'b0, req_valid_o}, {31'b0, vt[r].e_v});
      check("req_addr",  r, req_addr_o, vt[r].e_addr);
      check("halted",    r, {31'b0, halted_o}, {31'b0, vt[r].e_h});
      check("rdr_taken", r, {31'b0, rdr_taken_o}, {31'b0, vt[r].e_t});
      if (vt[r].e_t)
        check("rdr_idx", r, {31'b0, rdr_idx_o}, {31'b0, vt[r].e_i});
      check("misalign",  r, {31'b0, misalign_o}, {31'b0, vt[r].e_mis});
      check("err_addr",  r, err_addr_o, vt[r].e_err);
      tick();
    end

    // Hand-written: redirect beats hold (row 31 fired, pc is 0x44).
    rst = 0; rst_jtag_i = 0; hold_i = 1; halt_req_i = 0; req_ready_i = 1;
    rdr_vld_i = 2'b10; rdr_addr_i = {32'h80, 32'h0};
    #3;
    check("seq_hold_valid", 100, {31'b0, req_valid_o}, 32'h0);
    check("seq_hold_addr",  100, req_addr_o, 32'h44);
    tick();
    hold_i = 0; rdr_vld_i = 2'b00; req_ready_i = 0;
    #3;
    check("seq_rdr_addr",  101, req_addr_o, 32'h80);
    check("seq_rdr_taken", 101, {31'b0, rdr_taken_o}, 32'h1);
    check("seq_rdr_idx",   101, {31'b0, rdr_idx_o}, 32'h1);
    check("seq_rdr_valid", 101, {31'b0, req_valid_o}, 32'h1);
    tick();
    req_ready_i = 1;
    tick();
    #3;
    check("seq_step_addr", 102, req_addr_o, 32'h84);
    check("seq_taken_clr", 102, {31'b0, rdr_taken_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
